fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction register.
- Holds the fetch program counter and issues word reads to instruction memory over a req/ack handshake.
- Presents each fetched word on ins with ins_valid; ins_valid drives the IR load enable.
- Supports stalls from downstream and PC redirects from branch/jump logic, squashing in-flight fetches on redirect.

Parameters:
- DWIDTH, 16: instruction word width.
- AWIDTH, 8: instruction address width; memory is word-addressed.
- RESET_PC, 0: fetch PC value after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  fetch enable; while low, no new request is started.
- stall  in  1  downstream cannot accept; hold the current instruction.
- redirect  in  1  load redirect_pc into the fetch PC and squash the current instruction.
- redirect_pc  in  AWIDTH  redirect target address.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  AWIDTH  read address; stable while mem_req is high.
- mem_ack  in  1  memory read complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  DWIDTH  read data.
- ins  out  DWIDTH  fetched instruction; connects to IR ins.
- ins_valid  out  1  ins is valid; connects to IR en_in.
- pc  out  AWIDTH  address of the word currently on ins.

Behaviour:
- Reset (async):
  - state=IDLE, mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC.
  - ins=0, ins_valid=0, pc=RESET_PC.
  - Reset mid-request abandons the request with no drain.
- All outputs are registered. mem_addr always equals fetch_pc.
- States: IDLE, REQ, VALID, DRAIN. mem_req=1 in REQ and DRAIN; ins_valid=1 only in VALID.
- IDLE:
  - redirect: fetch_pc<=redirect_pc.
  - run=1: go to REQ next cycle (redirect and run in the same cycle → REQ at redirect_pc).
- REQ (mem_req held high, mem_addr held until ack):
  - ack & !redirect: ins<=mem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+1 (wraps 2^AWIDTH-1→0), go to VALID.
  - ack & redirect: discard data, fetch_pc<=redirect_pc; next state REQ if run, else IDLE.
  - !ack & redirect: go to DRAIN; fetch_pc is NOT updated yet; latch redirect_pc into pend_pc.
  - !ack & !redirect: stay in REQ. run going low does not abort an outstanding request.
- DRAIN (old request still open, address unchanged):
  - Further redirect: overwrite pend_pc.
  - On ack: discard data, fetch_pc<=pend_pc (or redirect_pc if redirect in the same cycle); next state REQ if run, else IDLE.
- VALID (ins/pc held stable):
  - redirect: ins_valid<=0, fetch_pc<=redirect_pc; next state REQ if run, else IDLE. Takes priority over stall.
  - stall=1: stay; IR reloads the same word each cycle, which is harmless.
  - stall=0: instruction consumed this cycle; next state REQ if run, else IDLE.
- Latency:
  - Ack in cycle N → ins_valid=1 in N+1.
  - Zero-wait memory (ack in the first REQ cycle) gives 1 instruction per 2 cycles.
- ins is updated only on an accepted ack. When leaving VALID, ins holds its last value with ins_valid=0.

Decomposition:
- Shared cpu package: state encoding localparams (IDLE=2'd0, REQ=2'd1, VALID=2'd2, DRAIN=2'd3), DWIDTH/AWIDTH defaults, RESET_PC.
- One natural sub-module, pc_reg: fetch_pc register with increment/wrap, load, and pend_pc latch. The FSM stays in fetch_unit.

Test Plan:
- Reset then run=1, memory returns ack one cycle after req with data 16'h1000+addr → ins sequence 1000,1001,1002 with pc 0,1,2; ins_valid pulses every 2nd cycle at minimum; mem_addr stable while mem_req is high.
- stall=1 for 3 cycles during VALID with ins=16'h1001 → ins and pc unchanged, ins_valid high for 4 cycles, no mem_req; first req after release uses addr 2.
- AWIDTH=8, redirect_pc=8'hFF, then fetch two words → pc 8'hFF then 8'h00.
- Redirect to 8'h40 while in REQ with ack delayed 3 cycles → mem_addr keeps the old value until ack, data discarded, ins_valid stays 0; next req at 8'h40.
- Redirect to 8'h20 in the same cycle as ack → data dropped, next cycle mem_req=1 at 8'h20; redirect in VALID with stall=1 → ins_valid=0 next cycle.
- Assert rst_n low mid-REQ → next edge mem_req=0, ins_valid=0, pc=RESET_PC, state IDLE; run=0 after ack → one final VALID, then IDLE with no req.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// reset PC and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int DWIDTH_DEF   = 16;
  localparam int AWIDTH_DEF   = 8;
  localparam int RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Fetch PC register: load, increment with natural wrap, and a pending
// redirect target held while an abandoned request drains.
module fetch_unit_pc_reg #(
  parameter int          AWIDTH   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [AWIDTH-1:0] load_val,
  input  logic              inc_en,
  input  logic              pend_en,
  input  logic [AWIDTH-1:0] pend_val,
  output logic [AWIDTH-1:0] fetch_pc,
  output logic [AWIDTH-1:0] pend_pc
);

  // NOTE: state uses non-blocking assignments and an async reset term in the
  // sensitivity list; blocking here would race with readers on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= AWIDTH'(RESET_PC);
      pend_pc  <= AWIDTH'(RESET_PC);
    end else begin
      if (load_en)
        fetch_pc <= load_val;
      else if (inc_en)
        fetch_pc <= fetch_pc + 1'b1;
      if (pend_en)
        pend_pc <= pend_val;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads words over a req/ack
// handshake and presents them to the IR with stall and redirect support.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DWIDTH   = DWIDTH_DEF,
  parameter int          AWIDTH   = AWIDTH_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              stall,
  input  logic              redirect,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              mem_req,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [DWIDTH-1:0] ins,
  output logic              ins_valid,
  output logic [AWIDTH-1:0] pc
);

  fetch_state_e      state;
  logic [AWIDTH-1:0] fetch_pc;
  logic [AWIDTH-1:0] pend_pc;
  logic [AWIDTH-1:0] load_val;
  logic              load_en;
  logic              inc_en;
  logic              pend_en;

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    load_en  = 1'b0;
    inc_en   = 1'b0;
    pend_en  = 1'b0;
    load_val = redirect_pc;
    case (state)
      IDLE:  load_en = redirect;
      REQ: begin
        if (mem_ack) begin
          load_en = redirect;
          inc_en  = !redirect;
        end else begin
          pend_en = redirect;
        end
      end
      // The open request keeps its address; the target only lands on ack.
      DRAIN: begin
        if (mem_ack) begin
          load_en  = 1'b1;
          load_val = redirect ? redirect_pc : pend_pc;
        end else begin
          pend_en = redirect;
        end
      end
      VALID: load_en = redirect;
      default: ;
    endcase
  end

  fetch_unit_pc_reg #(
    .AWIDTH   (AWIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (load_en),
    .load_val (load_val),
    .inc_en   (inc_en),
    .pend_en  (pend_en),
    .pend_val (redirect_pc),
    .fetch_pc (fetch_pc),
    .pend_pc  (pend_pc)
  );

  assign mem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      ins       <= '0;
      ins_valid <= 1'b0;
      pc        <= AWIDTH'(RESET_PC);
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state   <= REQ;
            mem_req <= 1'b1;
          end
        end
        REQ: begin
          if (mem_ack && !redirect) begin
            ins       <= mem_rdata;
            pc        <= fetch_pc;
            ins_valid <= 1'b1;
            mem_req   <= 1'b0;
            state     <= VALID;
          end else if (mem_ack) begin
            state   <= run ? REQ : IDLE;
            mem_req <= run;
          end else if (redirect) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            state   <= run ? REQ : IDLE;
            mem_req <= run;
          end
        end
        VALID: begin
          // Redirect wins over stall: the held word is squashed.
          if (redirect || !stall) begin
            ins_valid <= 1'b0;
            state     <= run ? REQ : IDLE;
            mem_req   <= run;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
